// File: rtl/lzw_cam_cell_array.sv
// LZW dictionary CAM: parallel search of NUM_CELL entries, allocate-on-miss, registered results.
// Optional CAM_FLUSH_EN adds a flush input that clears the dictionary like rst.
module lzw_cam_cell_array #(
  parameter int CAM_WIDTH = 8,
  parameter int NUM_CELL  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
`ifdef CAM_FLUSH_EN
  input  logic                        flush,
`endif
  input  logic                        en,
  input  logic [CAM_WIDTH-1:0]        search_key,
  output logic [$clog2(NUM_CELL)-1:0] cam_out,
  output logic                        cam_full,
  output logic                        match_found
);

  localparam int IDX_W = $clog2(NUM_CELL);

  logic [CAM_WIDTH-1:0] data [NUM_CELL];
  logic [NUM_CELL-1:0]  valid;
  logic [NUM_CELL-1:0]  valid_next;
  logic [NUM_CELL-1:0]  hit;
  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     hit_idx;
  logic                 any_hit;
  logic                 clear;
  logic                 do_write;

  // rst and flush clear identical state, so rst-over-flush priority needs no extra logic.
`ifdef CAM_FLUSH_EN
  assign clear = rst | flush;
`else
  assign clear = rst;
`endif

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CELL; i++) begin
      hit[i] = valid[i] && (data[i] == search_key);
    end
  end

  assign any_hit = |hit;

  // Scanning downward lets the lowest hit index win.
  always_comb begin
    // NOTE: default assignment first so the comb block can never infer a latch.
    hit_idx = '0;
    for (int i = NUM_CELL - 1; i >= 0; i--) begin
      if (hit[i]) hit_idx = IDX_W'(i);
    end
  end

  assign do_write = !clear && en && !any_hit && !cam_full;

  always_comb begin
    valid_next = valid;
    if (do_write) valid_next[wr_ptr] = 1'b1;
  end

  // NOTE: entry data has no reset; valid bits alone decide whether a cell can hit.
  always_ff @(posedge clk) begin
    if (do_write) data[wr_ptr] <= search_key;
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all sequential state.
    if (clear) begin
      valid       <= '0;
      wr_ptr      <= '0;
      cam_out     <= '0;
      match_found <= 1'b0;
      cam_full    <= 1'b0;
    end else begin
      valid       <= valid_next;
      cam_full    <= &valid_next;
      match_found <= en && any_hit;
      if (en && any_hit) begin
        cam_out <= hit_idx;
      end else if (do_write) begin
        cam_out <= wr_ptr;
        wr_ptr  <= wr_ptr + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lzw_cam_cell_array.sv
// Scoreboard bench for lzw_cam_cell_array (CAM_WIDTH=8, NUM_CELL=4); a key-queue model predicts each result.
module tb_lzw_cam_cell_array;

  typedef struct packed {
    logic [1:0] idx;
    logic       match;
    logic       full;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic       en = 1'b0;
  logic [7:0] search_key = '0;
  logic [1:0] cam_out;
  logic       cam_full;
  logic       match_found;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  logic [7:0] m_keys[$];
  logic [1:0] m_out = '0;
  logic       m_match = 1'b0;
  logic       m_full = 1'b0;

  always #5 clk = ~clk;

  lzw_cam_cell_array #(.CAM_WIDTH(8), .NUM_CELL(4)) dut (
    .clk         (clk),
    .rst         (rst),
`ifdef CAM_FLUSH_EN
    .flush       (flush),
`endif
    .en          (en),
    .search_key  (search_key),
    .cam_out     (cam_out),
    .cam_full    (cam_full),
    .match_found (match_found)
  );

  // Drive one cycle, advance the model, push its prediction; outputs are settled #1 after the edge.
  task automatic apply(input logic e, input logic [7:0] k, input logic r, input logic f);
    int found;
    @(negedge clk);
    rst = r; flush = f; en = e; search_key = k;
    if (r || f) begin
      m_keys.delete();
      m_out = '0; m_match = 1'b0; m_full = 1'b0;
    end else if (e) begin
      found = -1;
      foreach (m_keys[j]) if (found < 0 && m_keys[j] == k) found = j;
      if (found >= 0) begin
        m_match = 1'b1;
        m_out   = 2'(found);
      end else begin
        m_match = 1'b0;
        if (m_keys.size() < 4) begin
          m_out = 2'(m_keys.size());
          m_keys.push_back(k);
          m_full = (m_keys.size() == 4);
        end
      end
    end else begin
      m_match = 1'b0;
    end
    sb.push_back('{idx: m_out, match: m_match, full: m_full});
    @(posedge clk);
    #1;
    rst = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    exp_t x;
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    x = sb.pop_front();
    checks++;
    if ({cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
      errors++;
      $display("FAIL reset: got out=%0d match=%0b full=%0b want out=%0d match=%0b full=%0b",
               cam_out, match_found, cam_full, x.idx, x.match, x.full);
    end
    checks++;
    if ({cam_out, match_found, cam_full} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_const: got %b want 0000", {cam_out, match_found, cam_full});
    end
  endtask

  task automatic test_insert();
    logic [7:0] keys[2] = '{8'hFF, 8'hA5};
    logic [1:0] want[2] = '{2'd0, 2'd1};
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, keys[i], 1'b0, 1'b0);
      x = sb.pop_front();
      checks++;
      if (cam_out !== want[i] || match_found !== 1'b0 || {cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
        errors++;
        $display("FAIL insert key=%h: got out=%0d match=%0b full=%0b want out=%0d match=0 full=%0b",
                 keys[i], cam_out, match_found, cam_full, want[i], x.full);
      end
    end
  endtask

  task automatic test_hit();
    logic [7:0] keys[2] = '{8'hFF, 8'hA5};
    exp_t x;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, keys[i], 1'b0, 1'b0);
      x = sb.pop_front();
      checks++;
      if (cam_out !== 2'(i) || match_found !== 1'b1 || {cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
        errors++;
        $display("FAIL hit key=%h: got out=%0d match=%0b want out=%0d match=1", keys[i], cam_out, match_found, i);
      end
    end
  endtask

  task automatic test_fill();
    logic [7:0] keys[4] = '{8'h11, 8'h22, 8'h33, 8'hFF};
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, keys[i], 1'b0, 1'b0);
      x = sb.pop_front();
      checks++;
      if ({cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
        errors++;
        $display("FAIL fill key=%h: got out=%0d match=%0b full=%0b want out=%0d match=%0b full=%0b",
                 keys[i], cam_out, match_found, cam_full, x.idx, x.match, x.full);
      end
    end
    // Last observation is FF hitting index 0 in a full array: nothing was overwritten.
    checks++;
    if (cam_full !== 1'b1 || cam_out !== 2'd0 || match_found !== 1'b1) begin
      errors++;
      $display("FAIL fill_no_overwrite: got out=%0d match=%0b full=%0b want out=0 match=1 full=1",
               cam_out, match_found, cam_full);
    end
  endtask

  task automatic test_enable_low_zero_key();
    exp_t x;
    apply(1'b0, 8'h11, 1'b0, 1'b0);
    x = sb.pop_front();
    checks++;
    if (match_found !== 1'b0 || {cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
      errors++;
      $display("FAIL en_low: got out=%0d match=%0b full=%0b want out=%0d match=0 full=%0b",
               cam_out, match_found, cam_full, x.idx, x.full);
    end
    apply(1'b0, 8'h00, 1'b1, 1'b0);
    void'(sb.pop_front());
    apply(1'b1, 8'h00, 1'b0, 1'b0);
    x = sb.pop_front();
    checks++;
    if ({cam_out, match_found, cam_full} !== {x.idx, x.match, x.full} || match_found !== 1'b0) begin
      errors++;
      $display("FAIL zero_key: got out=%0d match=%0b full=%0b want out=0 match=0 full=0",
               cam_out, match_found, cam_full);
    end
    apply(1'b1, 8'h00, 1'b0, 1'b0);
    x = sb.pop_front();
    checks++;
    if ({cam_out, match_found} !== 3'b001 || {cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
      errors++;
      $display("FAIL zero_key_hit: got out=%0d match=%0b want out=0 match=1", cam_out, match_found);
    end
  endtask

  task automatic test_mid_reset(input logic use_flush);
    exp_t x;
    for (int i = 1; i < 4; i++) begin
      apply(1'b1, 8'(i), 1'b0, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (cam_full !== 1'b1) begin
      errors++;
      $display("FAIL pre_clear_full: got full=%0b want 1", cam_full);
    end
    // en stays high during the clear cycle to confirm clear outranks en.
    apply(1'b1, 8'h77, !use_flush, use_flush);
    x = sb.pop_front();
    checks++;
    if ({cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
      errors++;
      $display("FAIL clear(flush=%0b): got out=%0d match=%0b full=%0b want 0 0 0",
               use_flush, cam_out, match_found, cam_full);
    end
    apply(1'b1, 8'hFF, 1'b0, 1'b0);
    x = sb.pop_front();
    checks++;
    if (cam_out !== 2'd0 || match_found !== 1'b0 || {cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
      errors++;
      $display("FAIL after_clear: got out=%0d match=%0b full=%0b want out=0 match=0 full=0",
               cam_out, match_found, cam_full);
    end
  endtask

  task automatic test_back_to_back();
    exp_t x;
    for (int i = 0; i < 60; i++) begin
      apply(($urandom_range(0, 3) != 0), 8'($urandom_range(0, 6)), ($urandom_range(0, 19) == 0), 1'b0);
      x = sb.pop_front();
      checks++;
      if ({cam_out, match_found, cam_full} !== {x.idx, x.match, x.full}) begin
        errors++;
        $display("FAIL b2b[%0d]: got out=%0d match=%0b full=%0b want out=%0d match=%0b full=%0b",
                 i, cam_out, match_found, cam_full, x.idx, x.match, x.full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_insert();
    test_hit();
    test_fill();
    test_enable_low_zero_key();
    test_mid_reset(1'b0);
`ifdef CAM_FLUSH_EN
    test_mid_reset(1'b1);
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
